// File: rtl/shift_seq.sv
// Byte-serial shift sequencer: SLL/SRL/SRA on an NBYTES-wide operand, one byte per clock.
// Define SHIFT_SEQ_ROT_EN to turn op=11 into rotate-left; otherwise op=11 passes the operand through.
module shift_seq #(
    parameter int NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [2:0]            shamt,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   y
);
    localparam int W  = 8 * NBYTES;
    localparam int CW = $clog2(NBYTES);
    localparam int EW = W + 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    function automatic logic [7:0] sll8(input logic [7:0] x, input logic [3:0] n);
        return x << n;
    endfunction

    function automatic logic [7:0] srl8(input logic [7:0] x, input logic [3:0] n);
        return x >> n;
    endfunction

    function automatic logic [7:0] sra8(input logic [7:0] x, input logic [3:0] n);
        return $signed(x) >>> n;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  a_q, a_d;
    logic [1:0]    op_q, op_d;
    logic [2:0]    shamt_q, shamt_d;
    logic [W-1:0]  y_q, y_d;

    logic          right;
    logic [CW:0]   idx;
    logic [EW-1:0] ext;
    logic [7:0]    cur, lo, hi, res;
    logic [3:0]    s4, inv;
    logic          s_zero;
    logic [CW+3:0] lo_sh, cur_sh, hi_sh;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        op_d    = op_q;
        shamt_d = shamt_q;
        y_d     = y_q;

        // Right shifts walk from the top byte down so spill comes from the byte above.
        right  = (op_q == OP_SRL) || (op_q == OP_SRA);
        idx    = right ? ((CW+1)'(NBYTES - 1) - {1'b0, cnt_q}) : {1'b0, cnt_q};
        // Zero byte padded at each end makes the edge spill terms fall out naturally.
        ext    = {8'h00, a_q, 8'h00};
        lo_sh  = {idx, 3'b000};
        cur_sh = {idx + (CW+1)'(1), 3'b000};
        hi_sh  = {idx + (CW+1)'(2), 3'b000};
        lo     = ext[7:0] | 8'(ext >> lo_sh);
        cur    = 8'(ext >> cur_sh);
        hi     = 8'(ext >> hi_sh);
        s4     = {1'b0, shamt_q};
        inv    = 4'd8 - s4;
        s_zero = (shamt_q == 3'd0);

        case (op_q)
            OP_SLL: res = sll8(cur, s4) | (s_zero ? 8'h00 : srl8(lo, inv));
            OP_SRL: res = srl8(cur, s4) | (s_zero ? 8'h00 : sll8(hi, inv));
            OP_SRA: begin
                if (idx == (CW+1)'(NBYTES - 1)) res = sra8(cur, s4);
                else res = srl8(cur, s4) | (s_zero ? 8'h00 : sll8(hi, inv));
            end
`ifdef SHIFT_SEQ_ROT_EN
            OP_ROL: begin
                if (idx == '0) lo = a_q[W-1 -: 8];
                res = sll8(cur, s4) | (s_zero ? 8'h00 : srl8(lo, inv));
            end
`endif
            default: res = cur;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    op_d    = op;
                    shamt_d = shamt;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                y_d = (y_q & ~(W'(8'hFF) << lo_sh)) | (W'(res) << lo_sh);
                if (cnt_q == CW'(NBYTES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            op_q    <= '0;
            shamt_q <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            op_q    <= op_d;
            shamt_q <= shamt_d;
            y_q     <= y_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign y    = y_q;

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq (NBYTES=2): expected results queued at start, checked on done.
module tb_shift_seq;
    localparam int NB = 2;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [2:0]   shamt;
    logic         busy;
    logic         done;
    logic [W-1:0] y;

    int           n_chk  = 0;
    int           n_fail = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    shift_seq #(.NBYTES(NB)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a),
        .shamt(shamt), .busy(busy), .done(done), .y(y)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Whole-word reference, independent of the byte-serial structure of the DUT.
    function automatic logic [W-1:0] ref_shift(input logic [1:0] o, input logic [W-1:0] v,
                                               input logic [2:0] s);
        case (o)
            2'b00:   return v << s;
            2'b01:   return v >> s;
            2'b10:   return W'($signed(v) >>> s);
`ifdef SHIFT_SEQ_ROT_EN
            default: return (s == 3'd0) ? v : ((v << s) | (v >> (W - int'(s))));
`else
            default: return v;
`endif
        endcase
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) chk("unexpected_done", 64'(done), 64'd0);
            else chk("y_result", 64'(y), 64'(exp_q.pop_front()));
        end
    end

    // Called just after a rising edge with the DUT idle; checks handshake timing exactly.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] v, input logic [2:0] s,
                          input logic [W-1:0] expv);
        op = o; a = v; shamt = s; start = 1'b1;
        exp_q.push_back(expv);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < NB; i++) begin
            chk("run_busy", 64'(busy), 64'd1);
            chk("run_done", 64'(done), 64'd0);
            @(posedge clk); #1;
        end
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("done_drop", 64'(done), 64'd0);
    endtask

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra;
        logic [2:0]   rs;
        int           waited;

        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; shamt = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_y", 64'(y), 64'd0);

        run_op(2'b00, 16'hB3CA, 3'd3, 16'h9E50);
        run_op(2'b01, 16'hB3CA, 3'd4, 16'h0B3C);
        run_op(2'b10, 16'hB3CA, 3'd4, 16'hFB3C);
        run_op(2'b10, 16'h4000, 3'd7, 16'h0080);
        run_op(2'b00, 16'hA55A, 3'd0, 16'hA55A);
        run_op(2'b01, 16'hA55A, 3'd0, 16'hA55A);
        run_op(2'b10, 16'hA55A, 3'd0, 16'hA55A);
`ifdef SHIFT_SEQ_ROT_EN
        run_op(2'b11, 16'hB3CA, 3'd3, 16'h9E55);
`else
        run_op(2'b11, 16'hB3CA, 3'd3, 16'hB3CA);
`endif
        chk("y_hold", 64'(y), 64'(ref_shift(2'b11, 16'hB3CA, 3'd3)));

        // start held through RUN and DONE: only the first IDLE cycle may accept it
        op = 2'b00; a = 16'h0001; shamt = 3'd1; start = 1'b1;
        exp_q.push_back(16'h0002);
        @(posedge clk); #1;
        a = 16'hFFFF;
        exp_q.push_back(16'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_idle_busy", 64'(busy), 64'd0);
        chk("hold_idle_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        chk("hold_accept", 64'(busy), 64'd1);
        start = 1'b0;
        waited = 0;
        while (!done && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("hold_second_done", 64'(done), 64'd1);
        @(posedge clk); #1;
        chk("hold_no_third", 64'(busy), 64'd0);

        // reset during the first RUN cycle aborts with no done pulse
        op = 2'b10; a = 16'h8000; shamt = 3'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("abort_running", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_y", 64'(y), 64'd0);
        repeat (4) begin
            @(posedge clk); #1;
            chk("abort_quiet", 64'(done), 64'd0);
        end

        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = W'($urandom);
            rs = 3'($urandom_range(0, 7));
            run_op(ro, ra, rs, ref_shift(ro, ra, rs));
        end

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Multi-cycle controller that sequences the shared 8-bit shift primitives (sll8, srl8, sra8) to perform logical-left, logical-right and arithmetic-right shifts on an NBYTES-wide operand.
- Processes exactly one byte per clock, carrying spill bits between adjacent bytes.
- Sits beside the ALU in the Mega-8 datapath and serves 16-bit and wider shift instructions with a start/done handshake.

Parameters:
- NBYTES, 2, operand width in bytes (legal range 2..8); data width W = 8*NBYTES.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00=SLL, 01=SRL, 10=SRA, 11=reserved (see Optional Feature).
- a  input  W  operand, latched when start is accepted.
- shamt  input  3  shift amount 0..7, latched when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse in DONE.
- y  output  W  result register.

Behaviour:
- Reset: a synchronous reset, active-high, sampled on the rising edge of clk.
  - State becomes IDLE; busy=0, done=0, y=0; byte counter and latched operands are cleared.
  - Reset asserted mid-RUN or in DONE aborts the operation at that edge; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE: when start=1 at edge k, latch a/op/shamt, set cnt=0, go to RUN. start=0 stays in IDLE.
  - RUN: busy=1. Each edge writes one result byte and increments cnt. After NBYTES edges (edge k+NBYTES), go to DONE.
  - DONE: done=1, busy=0. Next edge goes to IDLE. start is ignored here.
- start seen while in RUN or DONE is ignored; it is not queued.
- Latency: done is high from edge k+NBYTES until edge k+NBYTES+1.
- y is updated only by RUN writes. It holds its value from DONE until the next accepted start.
- Byte arithmetic (b_i = byte i of the latched operand, s = shamt):
  - SLL: bytes processed in order 0..NBYTES-1. y_i = sll8(b_i,s) | srl8(b_{i-1},8-s). The spill term for byte 0 is 0.
  - SRL: bytes processed in order NBYTES-1..0. y_i = srl8(b_i,s) | sll8(b_{i+1},8-s). The spill term for the top byte is 0.
  - SRA: same as SRL, except the top byte uses sra8(b_top,s) so the sign bit fills.
  - s=0: spill terms are forced to 0 (8-s is not representable in 3 bits) and y=a. Full latency still applies.
- Only the byte selected by cnt is written per cycle. Intermediate y contents during RUN are undefined to consumers.
- op=11 without the macro: pass-through, y=a, full latency.
- All shifts are W-bit wide; bits shifted past either end are discarded. No carry or flag outputs.

Optional Feature:
- Macro: SHIFT_SEQ_ROT_EN.
- Defined: op=11 is ROL (rotate left).
  - Processed like SLL, but byte 0's spill term is srl8(b_top,8-s), so bits leaving the top wrap to bit 0.
  - s=0 still yields y=a.
- Undefined: op=11 is pass-through as described in Behaviour. No rotate logic is synthesized.

Test Plan:
- SLL, NBYTES=2, a=16'hB3CA, shamt=3, start pulse at edge k -> busy=1 over edges k+1..k+2; done=1 after edge k+2 only; y=16'h9E50.
- SRL a=16'hB3CA shamt=4 -> y=16'h0B3C. SRA with the same operands -> y=16'hFB3C. SRA a=16'h4000 shamt=7 -> y=16'h0080.
- shamt=0 with each of op=00, 01, 10 and a=16'hA55A -> y=16'hA55A; done still after 2 RUN cycles.
- Issue SLL a=16'h0001 shamt=1, then hold start=1 with a=16'hFFFF through RUN and DONE -> first result y=16'h0002. The second start is accepted only on the first IDLE cycle; its result is y=16'hFFFE.
- Assert rst for one cycle during the first RUN cycle of SRA a=16'h8000 shamt=2 -> next cycle busy=0, done=0, y=0, state IDLE; no done pulse follows.
- With SHIFT_SEQ_ROT_EN: op=11, a=16'hB3CA, shamt=3 -> y=16'h9E55. Without the macro: same stimulus -> y=16'hB3CA.
